uart_rx: RTL

UART receive front end. It turns the asynchronous `rx` line into framed bytes: 8N1 by default, or 8E1/8O1 when built with parity. Each good byte is presented on `dout` with a one-cycle `d_rdy` strobe, which matches the `dout`/`d_rdy` pair the UART controller forwards to the I/O controller. The block sits between the board RX pin and the UART controller's byte interface.

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronizer, mid-bit sampling, 8N1 framing by default.
// Define UART_RX_PARITY_EN for 8E1/8O1 framing (parity sense from PARITY_ODD).
module uart_rx #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 115_200,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       d_rdy,
   output logic       frm_err,
   output logic       par_err
);
   localparam int BIT_DIV = CLK_HZ / BAUD;
   localparam int CW      = $clog2(BIT_DIV);
   localparam logic [CW-1:0] CNT_MID = CW'(BIT_DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_END = CW'(BIT_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BRK
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    bitn, bitn_next;
   logic [7:0]    shreg, shreg_next;
   logic [7:0]    dout_next;
   logic          d_rdy_next, frm_err_next;
   logic          sync1, rxs;
`ifdef UART_RX_PARITY_EN
   logic          perr, perr_next, par_err_next;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bitn    <= '0;
         shreg   <= '0;
         dout    <= '0;
         d_rdy   <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bitn    <= bitn_next;
         shreg   <= shreg_next;
         dout    <= dout_next;
         d_rdy   <= d_rdy_next;
         frm_err <= frm_err_next;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perr    <= 1'b0;
         par_err <= 1'b0;
      end else begin
         perr    <= perr_next;
         par_err <= par_err_next;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^PARITY_ODD;
   assign par_err    = 1'b0;
`endif

   always_comb begin
      state_next   = state;
      cnt_next     = cnt + CW'(1);
      bitn_next    = bitn;
      shreg_next   = shreg;
      dout_next    = dout;
      d_rdy_next   = 1'b0;
      frm_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_next    = perr;
      par_err_next = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (!rxs) state_next = START;
         end
         START: begin
            if (cnt == CNT_MID) begin
               cnt_next   = '0;
               bitn_next  = '0;
               // a start bit that is high again by its middle was only a glitch
               state_next = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_END) begin
               cnt_next   = '0;
               shreg_next = {rxs, shreg[7:1]};
               bitn_next  = bitn + 3'd1;
               if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == CNT_END) begin
               cnt_next   = '0;
               perr_next  = ^shreg ^ rxs ^ (PARITY_ODD != 0);
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            // leaving at mid stop bit leaves half a bit to catch the next start edge
            if (cnt == CNT_END) begin
               cnt_next = '0;
               if (!rxs) begin
                  frm_err_next = 1'b1;
                  state_next   = BRK;
               end
`ifdef UART_RX_PARITY_EN
               else if (perr) begin
                  par_err_next = 1'b1;
                  state_next   = IDLE;
               end
`endif
               else begin
                  dout_next  = shreg;
                  d_rdy_next = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         BRK: begin
            cnt_next = '0;
            if (rxs) state_next = IDLE;
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end
endmodule
